// File: rtl/dmem_arbiter_if.sv
// Bundle between dmem_arbiter, its requesters and the shared data memory.
// The master side is the world around the arbiter: requesters plus the memory read data.
interface dmem_arbiter_if #(
  parameter int unsigned N_REQ  = 2,
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DATA_W = 8
);
  localparam int unsigned ID_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  logic [N_REQ-1:0]        req_valid;
  logic [N_REQ-1:0]        req_ready;
  logic [N_REQ-1:0]        req_we;
  logic [N_REQ*ADDR_W-1:0] req_addr;
  logic [N_REQ*DATA_W-1:0] req_wdata;

  logic                    rsp_valid;
  logic [ID_W-1:0]         rsp_id;
  logic [DATA_W-1:0]       rsp_rdata;

  logic                    mem_wen;
  logic [ADDR_W-1:0]       mem_addr;
  logic [DATA_W-1:0]       mem_wdata;
  logic [DATA_W-1:0]       mem_rdata;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, mem_rdata,
    input  req_ready, rsp_valid, rsp_id, rsp_rdata, mem_wen, mem_addr, mem_wdata
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, mem_rdata,
    output req_ready, rsp_valid, rsp_id, rsp_rdata, mem_wen, mem_addr, mem_wdata
  );
endinterface

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter and one-stage command sequencer for the shared 8-bit data memory.
// Optional per-requester grant/wait counters are built when DMEM_ARB_STATS_EN is defined.
module dmem_arbiter #(
  parameter int unsigned N_REQ  = 2,
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DATA_W = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  dmem_arbiter_if.slave         bus
`ifdef DMEM_ARB_STATS_EN
  ,
  output logic [N_REQ*16-1:0]   stat_grants,
  output logic [N_REQ*16-1:0]   stat_waits
`endif
);
  localparam int unsigned ID_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam logic [ID_W:0] N_REQ_L = (ID_W+1)'(N_REQ);

  logic [ID_W-1:0]    r_rr_ptr;
  logic               r_cmd_valid;
  logic               r_cmd_we;
  logic [ADDR_W-1:0]  r_cmd_addr;
  logic [DATA_W-1:0]  r_cmd_wdata;
  logic [ID_W-1:0]    r_cmd_id;
  logic               r_rsp_valid;
  logic [ID_W-1:0]    r_rsp_id;
  logic [DATA_W-1:0]  r_rsp_rdata;

  logic [2*N_REQ-1:0] w_rot;
  logic               w_any;
  logic [ID_W:0]      w_sum;
  logic [ID_W-1:0]    w_grant_id;
  logic [ID_W-1:0]    w_next_ptr;
  logic [N_REQ-1:0]   w_grant;
  logic               w_sel_we;
  logic [ADDR_W-1:0]  w_sel_addr;
  logic [DATA_W-1:0]  w_sel_wdata;

  // Rotate valids so bit 0 is the requester at rr_ptr; the lowest set bit then wins.
  assign w_rot = {bus.req_valid, bus.req_valid} >> r_rr_ptr;

  always_comb begin
    w_any = 1'b0;
    w_sum = '0;
    for (int j = 0; j < N_REQ; j++) begin
      if (!w_any && w_rot[j]) begin
        w_any = 1'b1;
        w_sum = {1'b0, r_rr_ptr} + (ID_W+1)'(j);
      end
    end
    if (reset) begin
      w_any = 1'b0;
    end
    w_grant_id = (w_sum >= N_REQ_L) ? ID_W'(w_sum - N_REQ_L) : ID_W'(w_sum);
    w_next_ptr = (w_grant_id == ID_W'(N_REQ - 1)) ? '0 : w_grant_id + 1'b1;
  end

  always_comb begin
    w_grant     = '0;
    w_sel_we    = 1'b0;
    w_sel_addr  = '0;
    w_sel_wdata = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (w_grant_id == ID_W'(i)) begin
        w_grant[i]  = w_any;
        w_sel_we    = bus.req_we[i];
        w_sel_addr  = bus.req_addr[i*ADDR_W +: ADDR_W];
        w_sel_wdata = bus.req_wdata[i*DATA_W +: DATA_W];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_rr_ptr    <= '0;
      r_cmd_valid <= 1'b0;
      r_cmd_we    <= 1'b0;
      r_cmd_addr  <= '0;
      r_cmd_wdata <= '0;
      r_cmd_id    <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_id    <= '0;
      r_rsp_rdata <= '0;
    end else begin
      r_cmd_valid <= w_any;
      if (w_any) begin
        r_rr_ptr    <= w_next_ptr;
        r_cmd_we    <= w_sel_we;
        r_cmd_addr  <= w_sel_addr;
        r_cmd_wdata <= w_sel_wdata;
        r_cmd_id    <= w_grant_id;
      end
      r_rsp_valid <= r_cmd_valid & ~r_cmd_we;
      if (r_cmd_valid && !r_cmd_we) begin
        r_rsp_id    <= r_cmd_id;
        r_rsp_rdata <= bus.mem_rdata;
      end
    end
  end

  assign bus.req_ready = w_grant;
  // Masking with reset keeps a dropped in-flight write from committing on the reset edge.
  assign bus.mem_wen   = r_cmd_valid & r_cmd_we & ~reset;
  assign bus.mem_addr  = r_cmd_addr;
  assign bus.mem_wdata = r_cmd_wdata;
  assign bus.rsp_valid = r_rsp_valid;
  assign bus.rsp_id    = r_rsp_id;
  assign bus.rsp_rdata = r_rsp_rdata;

`ifdef DMEM_ARB_STATS_EN
  logic [N_REQ-1:0][15:0] r_grants;
  logic [N_REQ-1:0][15:0] r_waits;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_grants <= '0;
      r_waits  <= '0;
    end else begin
      for (int i = 0; i < N_REQ; i++) begin
        if (w_grant[i] && (r_grants[i] != 16'hFFFF)) begin
          r_grants[i] <= r_grants[i] + 16'd1;
        end
        if (bus.req_valid[i] && !w_grant[i] && (r_waits[i] != 16'hFFFF)) begin
          r_waits[i] <= r_waits[i] + 16'd1;
        end
      end
    end
  end

  assign stat_grants = r_grants;
  assign stat_waits  = r_waits;
`endif
endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed, table-driven bench for dmem_arbiter with a behavioural 256x8 memory.
module tb_dmem_arbiter;
  logic clk = 1'b0;
  logic reset;
  logic tb_load;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  dmem_arbiter_if #(.N_REQ(2), .ADDR_W(8), .DATA_W(8)) bus ();

`ifdef DMEM_ARB_STATS_EN
  logic [31:0] stat_grants;
  logic [31:0] stat_waits;
`endif

  dmem_arbiter #(.N_REQ(2), .ADDR_W(8), .DATA_W(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
`ifdef DMEM_ARB_STATS_EN
    ,
    .stat_grants (stat_grants),
    .stat_waits  (stat_waits)
`endif
  );

  logic [7:0] mem [256];

  always @(posedge clk) begin
    if (tb_load) begin
      for (int i = 0; i < 256; i++) mem[i] <= 8'h00;
      mem[1] <= 8'h11;
      mem[2] <= 8'h22;
    end else if (bus.mem_wen) begin
      mem[bus.mem_addr] <= bus.mem_wdata;
    end
  end

  assign bus.mem_rdata = mem[bus.mem_addr];

  typedef struct {
    logic       rst;
    logic [1:0] valid;
    logic [1:0] we;
    logic [7:0] a0, a1, d0, d1;
    logic [1:0] ready;
    logic       wen;
    logic [7:0] maddr, mwdata;
    logic       rv;
    logic       rid;
    logic [7:0] rdata;
  } vec_t;

  vec_t tbl [27];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic rst, input logic [1:0] valid, input logic [1:0] we,
                       input logic [7:0] a0, input logic [7:0] a1,
                       input logic [7:0] d0, input logic [7:0] d1);
    reset         = rst;
    bus.req_valid = valid;
    bus.req_we    = we;
    bus.req_addr  = {a1, a0};
    bus.req_wdata = {d1, d0};
  endtask

  initial begin
    //          rst valid  we     a0     a1     d0     d1     ready  wen  maddr  mwdata rv  rid rdata
    tbl[0]  = '{1, 2'b11, 2'b00, 8'h00, 8'h00, 8'h00, 8'h00, 2'b00, 0, 8'h00, 8'h00, 0, 0, 8'h00};
    tbl[1]  = '{0, 2'b01, 2'b01, 8'h10, 8'h00, 8'hA5, 8'h00, 2'b01, 0, 8'h00, 8'h00, 0, 0, 8'h00};
    tbl[2]  = '{0, 2'b10, 2'b00, 8'h00, 8'h10, 8'h00, 8'h00, 2'b10, 1, 8'h10, 8'hA5, 0, 0, 8'h00};
    tbl[3]  = '{0, 2'b00, 2'b00, 8'h00, 8'h00, 8'h00, 8'h00, 2'b00, 0, 8'h10, 8'h00, 0, 0, 8'h00};
    tbl[4]  = '{0, 2'b00, 2'b00, 8'h00, 8'h00, 8'h00, 8'h00, 2'b00, 0, 8'h10, 8'h00, 1, 1, 8'hA5};
    tbl[5]  = '{0, 2'b11, 2'b00, 8'h01, 8'h02, 8'h00, 8'h00, 2'b01, 0, 8'h10, 8'h00, 0, 1, 8'hA5};
    tbl[6]  = '{0, 2'b11, 2'b00, 8'h01, 8'h02, 8'h00, 8'h00, 2'b10, 0, 8'h01, 8'h00, 0, 1, 8'hA5};
    tbl[7]  = '{0, 2'b11, 2'b00, 8'h01, 8'h02, 8'h00, 8'h00, 2'b01, 0, 8'h02, 8'h00, 1, 0, 8'h11};
    tbl[8]  = '{0, 2'b11, 2'b00, 8'h01, 8'h02, 8'h00, 8'h00, 2'b10, 0, 8'h01, 8'h00, 1, 1, 8'h22};
    tbl[9]  = '{0, 2'b00, 2'b00, 8'h00, 8'h00, 8'h00, 8'h00, 2'b00, 0, 8'h02, 8'h00, 1, 0, 8'h11};
    tbl[10] = '{0, 2'b00, 2'b00, 8'h00, 8'h00, 8'h00, 8'h00, 2'b00, 0, 8'h02, 8'h00, 1, 1, 8'h22};
    tbl[11] = '{0, 2'b01, 2'b01, 8'hFF, 8'h00, 8'h3C, 8'h00, 2'b01, 0, 8'h02, 8'h00, 0, 1, 8'h22};
    tbl[12] = '{0, 2'b01, 2'b00, 8'hFF, 8'h00, 8'h00, 8'h00, 2'b01, 1, 8'hFF, 8'h3C, 0, 1, 8'h22};
    tbl[13] = '{0, 2'b00, 2'b00, 8'h00, 8'h00, 8'h00, 8'h00, 2'b00, 0, 8'hFF, 8'h00, 0, 1, 8'h22};
    tbl[14] = '{0, 2'b00, 2'b00, 8'h00, 8'h00, 8'h00, 8'h00, 2'b00, 0, 8'hFF, 8'h00, 1, 0, 8'h3C};
    tbl[15] = '{0, 2'b10, 2'b10, 8'h00, 8'h30, 8'h00, 8'h5A, 2'b10, 0, 8'hFF, 8'h00, 0, 0, 8'h3C};
    tbl[16] = '{0, 2'b00, 2'b00, 8'h00, 8'h00, 8'h00, 8'h00, 2'b00, 1, 8'h30, 8'h5A, 0, 0, 8'h3C};
    tbl[17] = '{0, 2'b00, 2'b00, 8'h00, 8'h00, 8'h00, 8'h00, 2'b00, 0, 8'h30, 8'h5A, 0, 0, 8'h3C};
    tbl[18] = '{0, 2'b00, 2'b00, 8'h00, 8'h00, 8'h00, 8'h00, 2'b00, 0, 8'h30, 8'h5A, 0, 0, 8'h3C};
    tbl[19] = '{0, 2'b11, 2'b00, 8'h30, 8'h01, 8'h00, 8'h00, 2'b01, 0, 8'h30, 8'h5A, 0, 0, 8'h3C};
    tbl[20] = '{0, 2'b00, 2'b00, 8'h00, 8'h00, 8'h00, 8'h00, 2'b00, 0, 8'h30, 8'h00, 0, 0, 8'h3C};
    tbl[21] = '{0, 2'b00, 2'b00, 8'h00, 8'h00, 8'h00, 8'h00, 2'b00, 0, 8'h30, 8'h00, 1, 0, 8'h5A};
    tbl[22] = '{0, 2'b01, 2'b01, 8'h20, 8'h00, 8'h77, 8'h00, 2'b01, 0, 8'h30, 8'h00, 0, 0, 8'h5A};
    tbl[23] = '{1, 2'b11, 2'b00, 8'h00, 8'h00, 8'h00, 8'h00, 2'b00, 0, 8'h20, 8'h77, 0, 0, 8'h5A};
    tbl[24] = '{0, 2'b11, 2'b00, 8'h20, 8'h20, 8'h00, 8'h00, 2'b01, 0, 8'h00, 8'h00, 0, 0, 8'h00};
    tbl[25] = '{0, 2'b00, 2'b00, 8'h00, 8'h00, 8'h00, 8'h00, 2'b00, 0, 8'h20, 8'h00, 0, 0, 8'h00};
    tbl[26] = '{0, 2'b00, 2'b00, 8'h00, 8'h00, 8'h00, 8'h00, 2'b00, 0, 8'h20, 8'h00, 1, 0, 8'h00};

    tb_load = 1'b1;
    drive(1'b1, 2'b00, 2'b00, 8'h00, 8'h00, 8'h00, 8'h00);
    repeat (2) @(posedge clk);
    tb_load = 1'b0;

    // Inputs change on the falling edge; everything is sampled 1 time unit later.
    for (int i = 0; i < 27; i++) begin
      @(negedge clk);
      drive(tbl[i].rst, tbl[i].valid, tbl[i].we, tbl[i].a0, tbl[i].a1, tbl[i].d0, tbl[i].d1);
      #1;
      chk($sformatf("row%0d req_ready", i), 32'(bus.req_ready), 32'(tbl[i].ready));
      chk($sformatf("row%0d mem_wen", i), 32'(bus.mem_wen), 32'(tbl[i].wen));
      chk($sformatf("row%0d mem_addr", i), 32'(bus.mem_addr), 32'(tbl[i].maddr));
      chk($sformatf("row%0d mem_wdata", i), 32'(bus.mem_wdata), 32'(tbl[i].mwdata));
      chk($sformatf("row%0d rsp_valid", i), 32'(bus.rsp_valid), 32'(tbl[i].rv));
      chk($sformatf("row%0d rsp_id", i), 32'(bus.rsp_id), 32'(tbl[i].rid));
      chk($sformatf("row%0d rsp_rdata", i), 32'(bus.rsp_rdata), 32'(tbl[i].rdata));
    end

    // Read in flight when reset hits: it must vanish without a response.
    @(negedge clk);
    drive(1'b0, 2'b10, 2'b00, 8'h00, 8'h01, 8'h00, 8'h00);
    #1 chk("inflight grant", 32'(bus.req_ready), 32'h2);
    @(negedge clk);
    drive(1'b1, 2'b00, 2'b00, 8'h00, 8'h00, 8'h00, 8'h00);
    #1 chk("inflight reset wen", 32'(bus.mem_wen), 32'h0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      drive(1'b0, 2'b00, 2'b00, 8'h00, 8'h00, 8'h00, 8'h00);
      #1;
      chk($sformatf("inflight rsp_valid%0d", k), 32'(bus.rsp_valid), 32'h0);
      chk($sformatf("inflight rsp_rdata%0d", k), 32'(bus.rsp_rdata), 32'h0);
    end
    // Pointer back at 0 after reset: requester 0 wins a tie.
    @(negedge clk);
    drive(1'b0, 2'b11, 2'b00, 8'h00, 8'h00, 8'h00, 8'h00);
    #1 chk("post reset tie", 32'(bus.req_ready), 32'h1);

`ifdef DMEM_ARB_STATS_EN
    @(negedge clk);
    drive(1'b1, 2'b00, 2'b00, 8'h00, 8'h00, 8'h00, 8'h00);
    #1 chk("stats held in reset", 32'(bus.req_ready), 32'h0);
    repeat (3) begin
      @(negedge clk);
      drive(1'b0, 2'b11, 2'b00, 8'h01, 8'h02, 8'h00, 8'h00);
    end
    @(negedge clk);
    drive(1'b0, 2'b00, 2'b00, 8'h00, 8'h00, 8'h00, 8'h00);
    #1;
    chk("stat_grants0", 32'(stat_grants[15:0]), 32'd2);
    chk("stat_grants1", 32'(stat_grants[31:16]), 32'd1);
    chk("stat_waits0", 32'(stat_waits[15:0]), 32'd1);
    chk("stat_waits1", 32'(stat_waits[31:16]), 32'd2);
    drive(1'b0, 2'b01, 2'b00, 8'h01, 8'h00, 8'h00, 8'h00);
    repeat (70000) @(posedge clk);
    @(negedge clk);
    drive(1'b0, 2'b00, 2'b00, 8'h00, 8'h00, 8'h00, 8'h00);
    #1;
    chk("stat_grants0 saturate", 32'(stat_grants[15:0]), 32'hFFFF);
    chk("stat_grants1 unchanged", 32'(stat_grants[31:16]), 32'd1);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
